// File: rtl/elastic_buffer.sv
// Valid/ready elastic buffer: circular storage with registered occupancy, flush and
// a simultaneous push/pop path that keeps a full buffer streaming.
module elastic_buffer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [CW-1:0] AfCnt   = CW'(AF_LEVEL);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_rd_ptr_inc;
  logic [PW-1:0]    w_wr_ptr_inc;

  // A pop frees the slot in the same cycle, so a full buffer still accepts when out_ready=1.
  always_comb begin
    in_ready     = !flush && ((r_count < FullCnt) || out_ready);
    out_valid    = (r_count != '0) && !flush;
    w_push       = in_valid && in_ready;
    w_pop        = out_valid && out_ready;
    w_rd_ptr_inc = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
    w_wr_ptr_inc = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
    data_out     = r_mem[r_rd_ptr];
    count        = r_count;
    almost_full  = (r_count >= AfCnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      // Stored entries are left in place; only the bookkeeping is discarded.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_in;
        r_wr_ptr        <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
